// File: rtl/sha.sv
// sha: shared types and helpers for the SHA padder and engine.
//   mode_t      - hash variant; selects block size and length-field layout
//   msg_block_t - 1024-bit message block with 32-bit and 64-bit word views;
//                 w32[i] = bits [32i+31:32i]
//   PAD_WORD    - the 0x80 terminator byte sitting in the leading byte of a word
//   block_words - words per block (NW): 16 or 32
//   len_pos     - first word slot of the length field (LP): 14 or 28
package sha;

  typedef enum logic [2:0] {
    sha1       = 3'd0,
    sha224     = 3'd1,
    sha256     = 3'd2,
    sha384     = 3'd3,
    sha512     = 3'd4,
    sha512_224 = 3'd5,
    sha512_256 = 3'd6
  } mode_t;

  typedef union packed {
    logic [31:0][31:0] w32;
    logic [15:0][63:0] w64;
  } msg_block_t;

  localparam logic [31:0] PAD_WORD = 32'h8000_0000;

  function automatic logic is_64bit(input mode_t mode);
    return (mode == sha384) || (mode == sha512) ||
           (mode == sha512_224) || (mode == sha512_256);
  endfunction

  function automatic logic [5:0] block_words(input mode_t mode);
    return is_64bit(mode) ? 6'd32 : 6'd16;
  endfunction

  function automatic logic [5:0] len_pos(input mode_t mode);
    return is_64bit(mode) ? 6'd28 : 6'd14;
  endfunction

endpackage

// File: rtl/sha_padder_if.sv
// sha_padder_if: word-stream input and block output of the SHA padder.
//   in_valid/in_ready   - word handshake
//   in_data             - 32-bit big-endian word, [31:24] earliest byte
//   in_nbytes           - valid leading bytes (0..4)
//   in_last             - final word of the message
//   in_mode             - hash mode, taken from the first word of a message
//   out_valid/out_ready - block handshake toward the engine
//   out_msg             - padded block
//   out_mode            - mode of the message being emitted
//   out_new_msg         - block is the first of its message
// Modports: master drives the word stream and consumes blocks;
// slave is the padder itself.
interface sha_padder_if;
  import sha::*;

  logic       in_valid;
  logic       in_ready;
  logic [31:0] in_data;
  logic [2:0] in_nbytes;
  logic       in_last;
  mode_t      in_mode;
  logic       out_valid;
  logic       out_ready;
  msg_block_t out_msg;
  mode_t      out_mode;
  logic       out_new_msg;

  modport master (
    output in_valid, in_data, in_nbytes, in_last, in_mode, out_ready,
    input  in_ready, out_valid, out_msg, out_mode, out_new_msg
  );

  modport slave (
    input  in_valid, in_data, in_nbytes, in_last, in_mode, out_ready,
    output in_ready, out_valid, out_msg, out_mode, out_new_msg
  );

endinterface

// File: rtl/sha_padder.sv
// sha_padder: FIPS 180-4 message padding in front of sha_engine.
// Takes one 32-bit word per cycle, appends the 0x80 terminator, zero fill
// and the bit-length field, and emits whole 512/1024-bit blocks.
//   clk  - rising-edge clock
//   rstn - asynchronous active-low reset
//   bus  - sha_padder_if.slave (word input, block output)
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_FILL | accepting message words into the block buffer
// ST_PAD  | one cycle: place terminator and/or length field
// ST_SEND | block presented on out_msg, waiting for out_ready
module sha_padder
  import sha::*;
(
  input logic         clk,
  input logic         rstn,
  sha_padder_if.slave bus
);

  localparam logic [1:0] ST_FILL = 2'd0;
  localparam logic [1:0] ST_PAD  = 2'd1;
  localparam logic [1:0] ST_SEND = 2'd2;

  logic [1:0]  state_q;
  logic [5:0]  ptr_q;
  logic [60:0] byte_cnt_q;
  msg_block_t  buf_q;
  mode_t       mode_q;
  logic        armed_q;     // next accepted word starts a new message
  logic        new_msg_q;
  logic        pad_pend_q;  // terminator word still owed
  logic        len_pend_q;  // length field still owed (needs a fresh block)
  logic        final_q;     // block in ST_SEND closes the message

  mode_t       cur_mode;
  logic [5:0]  nw_cur;
  logic [5:0]  lp_cur;
  logic [4:0]  wr_idx;
  logic [5:0]  ptr_inc;
  logic [5:0]  pad_ptr;
  logic [63:0] bit_len;
  logic        accept;

  // Keep the leading nbytes, drop the 0x80 right after them, zero the rest.
  function automatic logic [31:0] pad_last(input logic [31:0] data,
                                           input logic [2:0]  nbytes);
    case (nbytes)
      3'd0:    return PAD_WORD;
      3'd1:    return {data[31:24], 8'h80, 16'h0000};
      3'd2:    return {data[31:16], 8'h80, 8'h00};
      3'd3:    return {data[31:8], 8'h80};
      default: return data;
    endcase
  endfunction

  // The first word of a message uses in_mode before it is latched.
  assign cur_mode = armed_q ? bus.in_mode : mode_q;
  assign nw_cur   = block_words(cur_mode);
  assign lp_cur   = len_pos(cur_mode);
  assign wr_idx   = 5'(nw_cur - 6'd1 - ptr_q);
  assign ptr_inc  = ptr_q + 6'd1;
  assign pad_ptr  = pad_pend_q ? ptr_inc : ptr_q;
  assign bit_len  = {byte_cnt_q, 3'b000};
  assign accept   = bus.in_valid && (state_q == ST_FILL);

  assign bus.in_ready    = (state_q == ST_FILL);
  assign bus.out_valid   = (state_q == ST_SEND);
  assign bus.out_msg     = buf_q;
  assign bus.out_mode    = mode_q;
  assign bus.out_new_msg = new_msg_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= ST_FILL;
      ptr_q      <= '0;
      byte_cnt_q <= '0;
      buf_q      <= '0;
      mode_q     <= sha1;
      armed_q    <= 1'b1;
      new_msg_q  <= 1'b0;
      pad_pend_q <= 1'b0;
      len_pend_q <= 1'b0;
      final_q    <= 1'b0;
    end else begin
      case (state_q)
        ST_FILL: begin
          if (accept) begin
            if (armed_q) begin
              mode_q    <= bus.in_mode;
              new_msg_q <= 1'b1;
              armed_q   <= 1'b0;
            end
            buf_q.w32[wr_idx] <= bus.in_last ? pad_last(bus.in_data, bus.in_nbytes)
                                             : bus.in_data;
            ptr_q      <= ptr_inc;
            byte_cnt_q <= byte_cnt_q + 61'(bus.in_nbytes);
            if (bus.in_last) begin
              pad_pend_q <= (bus.in_nbytes >= 3'd4);
              state_q    <= ST_PAD;
            end else if (ptr_inc == nw_cur) begin
              final_q <= 1'b0;
              state_q <= ST_SEND;
            end
          end
        end

        ST_PAD: begin
          state_q <= ST_SEND;
          if (ptr_q == nw_cur) begin
            // Buffer already full: flush it and finish in a fresh block.
            final_q    <= 1'b0;
            len_pend_q <= 1'b1;
          end else begin
            if (pad_pend_q) buf_q.w32[wr_idx] <= PAD_WORD;
            ptr_q      <= pad_ptr;
            pad_pend_q <= 1'b0;
            if (pad_ptr <= lp_cur) begin
              // Length always lands in the last two words; for 64-bit modes
              // the upper half of the 128-bit field stays zero.
              buf_q.w32[1] <= bit_len[63:32];
              buf_q.w32[0] <= bit_len[31:0];
              final_q      <= 1'b1;
              len_pend_q   <= 1'b0;
            end else begin
              final_q    <= 1'b0;
              len_pend_q <= 1'b1;
            end
          end
        end

        ST_SEND: begin
          if (bus.out_ready) begin
            buf_q     <= '0;
            ptr_q     <= '0;
            new_msg_q <= 1'b0;
            state_q   <= (pad_pend_q || len_pend_q) ? ST_PAD : ST_FILL;
            if (final_q) begin
              byte_cnt_q <= '0;
              armed_q    <= 1'b1;
              final_q    <= 1'b0;
            end
          end
        end

        default: state_q <= ST_FILL;
      endcase
    end
  end

endmodule

// File: tb/tb_sha_padder.sv
module tb_sha_padder;
  import sha::*;

  typedef logic [7:0] bq_t [$];
  typedef struct packed {
    msg_block_t msg;
    mode_t      mode;
    logic       new_msg;
  } exp_t;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  int         checks = 0;
  int         failures = 0;
  exp_t       exp_q [$];
  msg_block_t last_obs;
  bq_t        abc;
  bq_t        empty_msg;

  sha_padder_if bus ();

  sha_padder dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] obs,
                           input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  function automatic int first_diff(input msg_block_t a, input msg_block_t b);
    for (int i = 31; i >= 0; i--)
      if (a.w32[5'(i)] !== b.w32[5'(i)]) return i;
    return 0;
  endfunction

  task automatic check_blk(input string tag, input msg_block_t obs,
                           input msg_block_t expv);
    int i;
    checks++;
    assert (obs === expv) else begin
      failures++;
      i = first_diff(obs, expv);
      $error("FAIL %s w32[%0d] observed=%h expected=%h", tag, i,
             obs.w32[5'(i)], expv.w32[5'(i)]);
    end
  endtask

  task automatic report_timeout(input string tag);
    checks++;
    failures++;
    $error("FAIL %s timeout observed=no_event expected=event", tag);
  endtask

  function automatic bq_t mk_msg(input int len, input int seed);
    bq_t q;
    for (int i = 0; i < len; i++) q.push_back(8'(seed + 13 * i));
    return q;
  endfunction

  // Byte-level reference padding; pushes one expected entry per block.
  function automatic int model_push(input bq_t msg, input mode_t m);
    bq_t         p;
    int          nw, blk, lf, nblk;
    logic [63:0] bitlen;
    msg_block_t  bv;
    exp_t        e;
    nw  = (m == sha384 || m == sha512 || m == sha512_224 || m == sha512_256) ? 32 : 16;
    blk = nw * 4;
    lf  = (nw == 32) ? 16 : 8;
    p   = msg;
    p.push_back(8'h80);
    while ((p.size() % blk) != blk - lf) p.push_back(8'h00);
    if (lf == 16) repeat (8) p.push_back(8'h00);
    bitlen = 64'(msg.size()) * 64'd8;
    for (int k = 7; k >= 0; k--) p.push_back(bitlen[k*8 +: 8]);
    nblk = p.size() / blk;
    for (int b = 0; b < nblk; b++) begin
      bv = '0;
      for (int k = 0; k < blk; k++)
        bv.w32[5'(nw - 1 - k / 4)][(3 - k % 4) * 8 +: 8] = p[b * blk + k];
      e.msg     = bv;
      e.mode    = m;
      e.new_msg = (b == 0);
      exp_q.push_back(e);
    end
    return nblk;
  endfunction

  task automatic send_msg(input bq_t msg, input mode_t m, input mode_t m_later);
    int          nwords, n, rem;
    logic [31:0] word;
    nwords = (msg.size() == 0) ? 1 : (msg.size() + 3) / 4;
    for (int w = 0; w < nwords; w++) begin
      rem  = msg.size() - w * 4;
      word = 32'hA5A5_A5A5;
      for (int b = 0; b < 4; b++)
        if (b < rem) word[31 - 8 * b -: 8] = msg[w * 4 + b];
      n = 0;
      @(negedge clk);
      while (!bus.in_ready && n < 500) begin
        @(negedge clk);
        n++;
      end
      if (!bus.in_ready) begin
        report_timeout("in_ready");
        return;
      end
      bus.in_valid  = 1'b1;
      bus.in_data   = word;
      bus.in_nbytes = (rem >= 4) ? 3'd4 : 3'(rem);
      bus.in_last   = (w == nwords - 1);
      bus.in_mode   = (w == 0) ? m : m_later;
      @(posedge clk);
      #1 bus.in_valid = 1'b0;
      bus.in_last = 1'b0;
    end
  endtask

  task automatic recv_block(input string tag, input int hold);
    int   n;
    exp_t e;
    n = 0;
    @(negedge clk);
    while (!bus.out_valid && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (!bus.out_valid) begin
      report_timeout({tag, ".out_valid"});
      return;
    end
    if (exp_q.size() == 0) begin
      report_timeout({tag, ".scoreboard_empty"});
      return;
    end
    e = exp_q.pop_front();
    for (int c = 0; c < hold; c++) begin
      check_blk({tag, ".hold_msg"}, bus.out_msg, e.msg);
      check_val({tag, ".hold_valid"}, 64'(bus.out_valid), 64'd1);
      check_val({tag, ".hold_in_ready"}, 64'(bus.in_ready), 64'd0);
      @(negedge clk);
    end
    check_blk({tag, ".msg"}, bus.out_msg, e.msg);
    check_val({tag, ".mode"}, 64'(bus.out_mode), 64'(e.mode));
    check_val({tag, ".new_msg"}, 64'(bus.out_new_msg), 64'(e.new_msg));
    last_obs = bus.out_msg;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1 bus.out_ready = 1'b0;
  endtask

  task automatic run_msg(input string tag, input bq_t msg, input mode_t m,
                         input mode_t m_later, input int hold);
    int nb;
    nb = model_push(msg, m);
    fork
      send_msg(msg, m, m_later);
      begin
        for (int i = 0; i < nb; i++) recv_block(tag, (i == 0) ? hold : 0);
      end
    join
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_nbytes = '0;
    bus.in_last   = 1'b0;
    bus.in_mode   = sha1;
    bus.out_ready = 1'b0;
    abc = '{8'h61, 8'h62, 8'h63};

    rstn = 1'b0;
    repeat (2) @(negedge clk);
    check_val("rst.in_ready", 64'(bus.in_ready), 64'd1);
    check_val("rst.out_valid", 64'(bus.out_valid), 64'd0);
    check_blk("rst.out_msg", bus.out_msg, '0);
    check_val("rst.new_msg", 64'(bus.out_new_msg), 64'd0);
    check_val("rst.mode", 64'(bus.out_mode), 64'(sha1));
    rstn = 1'b1;

    run_msg("abc256", abc, sha256, sha256, 0);
    check_val("abc256.w15", 64'(last_obs.w32[15]), 64'h6162_6380);
    check_val("abc256.w0", 64'(last_obs.w32[0]), 64'h18);

    run_msg("empty512", empty_msg, sha512, sha512, 0);
    check_val("empty512.w31", 64'(last_obs.w32[31]), 64'h8000_0000);

    run_msg("m56_256", mk_msg(56, 1), sha256, sha256, 0);
    check_val("m56_256.blk2_w0", 64'(last_obs.w32[0]), 64'h1C0);

    run_msg("m64_sha1", mk_msg(64, 2), sha1, sha1, 0);
    check_val("m64_sha1.blk2_w15", 64'(last_obs.w32[15]), 64'h8000_0000);
    check_val("m64_sha1.blk2_w0", 64'(last_obs.w32[0]), 64'h200);

    run_msg("m55_224", mk_msg(55, 3), sha224, sha224, 0);
    run_msg("m63_256", mk_msg(63, 4), sha256, sha256, 0);
    run_msg("m111_384", mk_msg(111, 5), sha384, sha384, 0);
    run_msg("m112_512_224", mk_msg(112, 6), sha512_224, sha512_224, 0);
    run_msg("mode_change", mk_msg(20, 7), sha256, sha512, 0);

    run_msg("hold", mk_msg(10, 8), sha512_256, sha512_256, 10);
    check_val("hold.post_hs_in_ready", 64'(bus.in_ready), 64'd1);

    for (int w = 0; w < 5; w++) begin
      @(negedge clk);
      bus.in_valid  = 1'b1;
      bus.in_data   = 32'(32'h1000_0000 + w);
      bus.in_nbytes = 3'd4;
      bus.in_last   = 1'b0;
      bus.in_mode   = sha384;
      @(posedge clk);
      #1 bus.in_valid = 1'b0;
    end
    @(negedge clk);
    rstn = 1'b0;
    #1;
    check_val("midrst.in_ready", 64'(bus.in_ready), 64'd1);
    check_val("midrst.out_valid", 64'(bus.out_valid), 64'd0);
    check_blk("midrst.out_msg", bus.out_msg, '0);
    check_val("midrst.new_msg", 64'(bus.out_new_msg), 64'd0);
    check_val("midrst.mode", 64'(bus.out_mode), 64'(sha1));
    @(negedge clk);
    rstn = 1'b1;

    run_msg("abc_after_rst", abc, sha256, sha256, 0);
    check_val("abc_after_rst.w15", 64'(last_obs.w32[15]), 64'h6162_6380);

    check_val("scoreboard_drained", 64'(exp_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
